// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// Fault manager for a triplicated pipeline stage: scores per-replica voter disagreements,
// resyncs a replica that crosses THRESH, and raises a sticky alarm. Optional decay: TMR_FAULT_DECAY_EN.
module cv32e40p_tmr_fault_ctrl #(
    parameter int CNT_W         = 4,
    parameter int THRESH        = 3,
    parameter int RST_CYCLES    = 4,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int DECAY_PERIOD  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  err_rep_i,
    input  logic        pipe_idle_i,
    input  logic        clear_i,
    output logic        stall_o,
    output logic [2:0]  replica_rst_o,
    output logic        resync_busy_o,
    output logic [1:0]  faulty_id_o,
    output logic        fatal_o,
    output logic [15:0] err_total_o
);

    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] SCORE_MAX = '1;

    if (THRESH < 1 || THRESH > (2**CNT_W) - 1) begin : g_bad_thresh
        $error("THRESH out of range");
    end
    if (RST_CYCLES < 1 || DRAIN_TIMEOUT < 1 || DECAY_PERIOD < 1) begin : g_bad_cycles
        $error("cycle parameters must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, DRAIN, RESYNC, RELEASE, FATAL} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] score_q [3];
    logic [CNT_W-1:0] score_d [3];
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       faulty_id_q, faulty_id_d;
    logic             stall_q, stall_d;
    logic             busy_q, busy_d;
    logic             fatal_q, fatal_d;
    logic [2:0]       rrst_q, rrst_d;
    logic [15:0]      total_q, total_d;

    logic [2:0] mask, err_vis;
    logic       any_err, multi_err, single_err, decay_tick, to_fatal, hit;
    logic [1:0] hit_id;

    // The replica being reset or settling cannot vote, so its flag is ignored.
    assign mask       = (state_q == RESYNC || state_q == RELEASE) ? (3'b001 << faulty_id_q) : 3'b000;
    assign err_vis    = err_rep_i & ~mask;
    assign any_err    = |err_vis;
    assign multi_err  = (err_vis[0] & err_vis[1]) | (err_vis[0] & err_vis[2]) | (err_vis[1] & err_vis[2]);
    assign single_err = any_err & ~multi_err;

    always_comb begin
        hit    = 1'b0;
        hit_id = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (score_q[i] >= CNT_W'(THRESH)) begin
                hit    = 1'b1;
                hit_id = 2'(i);
            end
        end
    end

`ifdef TMR_FAULT_DECAY_EN
    localparam int DEC_W = $clog2(DECAY_PERIOD + 1);
    logic [DEC_W-1:0] decay_cnt_q, decay_cnt_d;

    always_comb begin
        decay_cnt_d = '0;
        decay_tick  = 1'b0;
        if (err_rep_i == 3'b000) begin
            if (decay_cnt_q == DEC_W'(DECAY_PERIOD - 1)) decay_tick = 1'b1;
            else decay_cnt_d = decay_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) decay_cnt_q <= '0;
        else     decay_cnt_q <= decay_cnt_d;
    end
`else
    assign decay_tick = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        faulty_id_d = faulty_id_q;
        stall_d     = stall_q;
        busy_d      = busy_q;
        fatal_d     = fatal_q;
        rrst_d      = rrst_q;
        total_d     = total_q;
        score_d     = score_q;
        to_fatal    = 1'b0;

        if (any_err && total_q != 16'hFFFF) total_d = total_q + 16'd1;
        for (int i = 0; i < 3; i++) begin
            if (single_err && err_vis[i] && score_q[i] != SCORE_MAX) score_d[i] = score_q[i] + 1'b1;
            else if (decay_tick && score_q[i] != '0)                  score_d[i] = score_q[i] - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (multi_err) to_fatal = 1'b1;
                else if (hit) begin
                    state_d     = DRAIN;
                    faulty_id_d = hit_id;
                    timer_d     = '0;
                    stall_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            DRAIN: begin
                if (multi_err) to_fatal = 1'b1;
                else if (pipe_idle_i) begin
                    state_d = RESYNC;
                    timer_d = '0;
                    rrst_d  = 3'b001 << faulty_id_q;
                end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) to_fatal = 1'b1;
                else timer_d = timer_q + 1'b1;
            end
            RESYNC: begin
                score_d[faulty_id_q] = '0;
                // With one replica down, any remaining disagreement leaves no majority.
                if (any_err) to_fatal = 1'b1;
                else if (timer_q == TMR_W'(RST_CYCLES - 1)) begin
                    state_d = RELEASE;
                    rrst_d  = 3'b000;
                end else timer_d = timer_q + 1'b1;
            end
            RELEASE: begin
                if (any_err) to_fatal = 1'b1;
                else begin
                    state_d = IDLE;
                    stall_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            FATAL: ;
            default: to_fatal = 1'b1;
        endcase

        if (to_fatal) begin
            state_d = FATAL;
            fatal_d = 1'b1;
            stall_d = 1'b1;
            busy_d  = 1'b0;
            rrst_d  = 3'b000;
        end

        if (clear_i) begin
            state_d     = IDLE;
            timer_d     = '0;
            faulty_id_d = 2'd3;
            stall_d     = 1'b0;
            busy_d      = 1'b0;
            fatal_d     = 1'b0;
            rrst_d      = 3'b000;
            total_d     = 16'd0;
            for (int i = 0; i < 3; i++) score_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            faulty_id_q <= 2'd3;
            stall_q     <= 1'b0;
            busy_q      <= 1'b0;
            fatal_q     <= 1'b0;
            rrst_q      <= 3'b000;
            total_q     <= 16'd0;
            for (int i = 0; i < 3; i++) score_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            faulty_id_q <= faulty_id_d;
            stall_q     <= stall_d;
            busy_q      <= busy_d;
            fatal_q     <= fatal_d;
            rrst_q      <= rrst_d;
            total_q     <= total_d;
            for (int i = 0; i < 3; i++) score_q[i] <= score_d[i];
        end
    end

    assign stall_o       = stall_q;
    assign replica_rst_o = rrst_q;
    assign resync_busy_o = busy_q;
    assign faulty_id_o   = faulty_id_q;
    assign fatal_o       = fatal_q;
    assign err_total_o   = total_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_ctrl.sv
// Scoreboard bench for cv32e40p_tmr_fault_ctrl: directed scenarios plus random traffic
// against a behavioural model; honours TMR_FAULT_DECAY_EN like the design.
module tb_cv32e40p_tmr_fault_ctrl;
    localparam int CNT_W         = 4;
    localparam int THRESH        = 3;
    localparam int RST_CYCLES    = 4;
    localparam int DRAIN_TIMEOUT = 64;
    localparam int DECAY_PERIOD  = 16;
    localparam int SCORE_MAX     = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  err_rep = 3'b000;
    logic        pipe_idle = 1'b0;
    logic        clr = 1'b0;
    logic        stall;
    logic [2:0]  replica_rst;
    logic        busy;
    logic [1:0]  faulty_id;
    logic        fatal;
    logic [15:0] err_total;

    cv32e40p_tmr_fault_ctrl #(
        .CNT_W(CNT_W), .THRESH(THRESH), .RST_CYCLES(RST_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .DECAY_PERIOD(DECAY_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .err_rep_i(err_rep), .pipe_idle_i(pipe_idle), .clear_i(clr),
        .stall_o(stall), .replica_rst_o(replica_rst), .resync_busy_o(busy),
        .faulty_id_o(faulty_id), .fatal_o(fatal), .err_total_o(err_total)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic [2:0]  rrst;
        logic        busy;
        logic [1:0]  fid;
        logic        fatal;
        logic [15:0] total;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: what the controller is doing, in plain terms.
    typedef enum int {P_IDLE, P_DRAIN, P_RESYNC, P_RELEASE, P_FATAL} phase_e;
    phase_e ph;
    int score [3];
    int total, fid, waited, rst_left, clean_run;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.stall = (ph != P_IDLE);
        e.rrst  = (ph == P_RESYNC) ? 3'(1 << fid) : 3'b000;
        e.busy  = (ph == P_DRAIN || ph == P_RESYNC || ph == P_RELEASE);
        e.fid   = 2'(fid);
        e.fatal = (ph == P_FATAL);
        e.total = 16'(total);
        return e;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; total = 0; fid = 3; waited = 0; rst_left = 0; clean_run = 0;
        for (int i = 0; i < 3; i++) score[i] = 0;
    endtask

    task automatic model_step(input logic [2:0] e, input logic idl, input logic c);
        logic [2:0] vis;
        int n, old [3], pick;
        bit decay;
        decay = 0;
`ifdef TMR_FAULT_DECAY_EN
        if (e == 3'b000) begin
            clean_run++;
            if (clean_run == DECAY_PERIOD) begin decay = 1; clean_run = 0; end
        end else clean_run = 0;
`endif
        if (c) begin
            ph = P_IDLE; total = 0; fid = 3;
            for (int i = 0; i < 3; i++) score[i] = 0;
            return;
        end
        vis = e;
        if (ph == P_RESYNC || ph == P_RELEASE) vis[fid] = 1'b0;
        n = $countones(vis);
        if (n > 0 && total < 65535) total++;
        for (int i = 0; i < 3; i++) begin
            old[i] = score[i];
            if (n == 1 && vis[i]) score[i] = (score[i] < SCORE_MAX) ? score[i] + 1 : SCORE_MAX;
            else if (decay && score[i] > 0) score[i]--;
        end
        if (ph == P_RESYNC) score[fid] = 0;
        case (ph)
            P_IDLE: begin
                pick = -1;
                for (int i = 2; i >= 0; i--) if (old[i] >= THRESH) pick = i;
                if (n >= 2) ph = P_FATAL;
                else if (pick >= 0) begin ph = P_DRAIN; fid = pick; waited = 0; end
            end
            P_DRAIN: begin
                if (n >= 2) ph = P_FATAL;
                else if (idl) begin ph = P_RESYNC; rst_left = RST_CYCLES; end
                else begin
                    waited++;
                    if (waited == DRAIN_TIMEOUT) ph = P_FATAL;
                end
            end
            P_RESYNC: begin
                if (n >= 1) ph = P_FATAL;
                else begin
                    rst_left--;
                    if (rst_left == 0) ph = P_RELEASE;
                end
            end
            P_RELEASE: ph = (n >= 1) ? P_FATAL : P_IDLE;
            default: ;
        endcase
    endtask

    task automatic cycle(input logic [2:0] e, input logic idl, input logic c);
        @(negedge clk);
        rst = 1'b0; err_rep = e; pipe_idle = idl; clr = c;
        model_step(e, idl, c);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_cycles(input int n, input logic idl);
        for (int i = 0; i < n; i++) cycle(3'b000, idl, 1'b0);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1; err_rep = 3'b000; pipe_idle = 1'b0; clr = 1'b0;
        model_reset();
        e = model_out();
        #1;
        check("rst_stall", 16'(stall), 16'(e.stall));
        check("rst_replica_rst", 16'(replica_rst), 16'(e.rrst));
        check("rst_busy", 16'(busy), 16'(e.busy));
        check("rst_faulty_id", 16'(faulty_id), 16'(e.fid));
        check("rst_fatal", 16'(fatal), 16'(e.fatal));
        check("rst_err_total", err_total, e.total);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: the controller presents its outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", 16'(stall), 16'(e.stall));
                check("replica_rst", 16'(replica_rst), 16'(e.rrst));
                check("busy", 16'(busy), 16'(e.busy));
                check("faulty_id", 16'(faulty_id), 16'(e.fid));
                check("fatal", 16'(fatal), 16'(e.fatal));
                check("err_total", err_total, e.total);
            end
        end
    end

    initial begin
        int r;
        logic [2:0] e;
        logic       hold_pipe;
        model_reset();
        do_reset();

        // Replica 1 disagrees three separate times, then a full resync.
        for (int k = 0; k < 3; k++) begin
            cycle(3'b010, 1'b1, 1'b0);
            idle_cycles(2, 1'b1);
        end
        idle_cycles(12, 1'b1);

        // No majority in IDLE, then clear.
        cycle(3'b011, 1'b1, 1'b0);
        idle_cycles(4, 1'b1);
        cycle(3'b000, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);

        // Drain never completes on replica 0.
        for (int k = 0; k < 3; k++) cycle(3'b001, 1'b0, 1'b0);
        idle_cycles(DRAIN_TIMEOUT + 6, 1'b0);
        cycle(3'b000, 1'b0, 1'b1);

        // Replica 2 keeps disagreeing through its own resync.
        for (int k = 0; k < 3; k++) cycle(3'b100, 1'b1, 1'b0);
        idle_cycles(2, 1'b1);
        for (int k = 0; k < 5; k++) cycle(3'b100, 1'b1, 1'b0);
        idle_cycles(6, 1'b1);
        cycle(3'b000, 1'b1, 1'b1);

        // Replicas 0 and 2 both cross while replica 1 is draining.
        for (int k = 0; k < 3; k++) cycle(3'b010, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(3'b001, 1'b0, 1'b0);
            cycle(3'b100, 1'b0, 1'b0);
        end
        idle_cycles(30, 1'b1);
        cycle(3'b000, 1'b1, 1'b1);

        // Two hits on replica 1, a long clean stretch, then one more hit.
        cycle(3'b010, 1'b1, 1'b0);
        cycle(3'b010, 1'b1, 1'b0);
        idle_cycles(2 * DECAY_PERIOD + 8, 1'b1);
        cycle(3'b010, 1'b1, 1'b0);
        idle_cycles(12, 1'b1);

        // Asynchronous reset in the middle of a resync.
        for (int k = 0; k < 3; k++) cycle(3'b001, 1'b1, 1'b0);
        idle_cycles(4, 1'b1);
        do_reset();
        idle_cycles(3, 1'b1);

        // Random traffic with alternating drain behaviour.
        hold_pipe = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (k % 250 == 0) hold_pipe = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 99);
            if (r < 8)       e = 3'(1 << $urandom_range(0, 2));
            else if (r == 8) e = 3'($urandom_range(3, 7)) | 3'b011;
            else             e = 3'b000;
            if ($urandom_range(0, 599) == 0) do_reset();
            else cycle(e, hold_pipe ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 199) == 0));
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
